// File: rtl/alu_iterativa_pkg.sv
// Shared op codes, FSM state encoding and op classification for the iterative ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_iterativa_if.sv
// Control word, operands and start/busy/done handshake between the datapath and the ALU.
interface alu_iterativa_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [3:0]       ALUoperation_i;
  logic             c_i;
  logic             invert_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             lt_o;

  modport master (
    output start_i, ALUoperation_i, c_i, invert_i, a_i, b_i,
    input  busy_o, done_o, result_o, zero_o, lt_o
  );

  modport slave (
    input  start_i, ALUoperation_i, c_i, invert_i, a_i, b_i,
    output busy_o, done_o, result_o, zero_o, lt_o
  );
endinterface

// File: rtl/alu_iterativa_sumador.sv
// Combinational adder shared by add/sub/slt/sltu and the zero/less-than flags.
module alu_sumador #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             invert,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff    = invert ? ~b : b;
  assign full     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c};
  assign sum      = full[WIDTH-1:0];
  assign carry    = full[WIDTH];
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_iterativa.sv
// Multicycle ALU: logic/arith ops finish in one cycle, shifts move one bit per cycle.
module alu_iterativa
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic            clk_i,
  input logic            rst_ni,
  alu_iterativa_if.slave bus
);

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic               c_q, inv_q;
  logic [WIDTH-1:0]   a_q, b_q, shreg_q, result_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               zero_q, lt_q;

  logic [3:0]         op_sel;
  logic               c_sel, inv_sel;
  logic [WIDTH-1:0]   a_sel, b_sel;
  logic [WIDTH-1:0]   sum;
  logic               carry, ovf;
  logic               lt_signed, lt_val, zero_val;
  logic [WIDTH-1:0]   alu_val, shift_next;
  logic [SHAMT_W-1:0] shamt_in;
  logic               idle;

  assign idle     = (state_q == ST_IDLE);
  assign shamt_in = bus.b_i[SHAMT_W-1:0];

  // While idle the adder sees the live inputs so a one-cycle op can register at once;
  // afterwards it sees the latched operands so flags at the end of a shift stay consistent.
  always_comb begin
    op_sel  = idle ? bus.ALUoperation_i : op_q;
    c_sel   = idle ? bus.c_i            : c_q;
    inv_sel = idle ? bus.invert_i       : inv_q;
    a_sel   = idle ? bus.a_i            : a_q;
    b_sel   = idle ? bus.b_i            : b_q;
  end

  alu_sumador #(.WIDTH(WIDTH)) u_sumador (
    .a        (a_sel),
    .b        (b_sel),
    .invert   (inv_sel),
    .c        (c_sel),
    .sum      (sum),
    .carry    (carry),
    .overflow (ovf)
  );

  assign lt_signed = sum[WIDTH-1] ^ ovf;
  assign lt_val    = (op_sel == OP_SLTU) ? ~carry : lt_signed;
  assign zero_val  = (sum == '0);

  always_comb begin
    alu_val = '0;
    case (op_sel)
      OP_ADD, OP_SUB: alu_val = sum;
      OP_AND:         alu_val = a_sel & b_sel;
      OP_OR:          alu_val = a_sel | b_sel;
      OP_XOR:         alu_val = a_sel ^ b_sel;
      OP_SLT:         alu_val = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU:        alu_val = {{(WIDTH-1){1'b0}}, ~carry};
      default:        alu_val = '0;
    endcase
  end

  always_comb begin
    shift_next = shreg_q;
    case (op_q)
      OP_SLL:  shift_next = {shreg_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, shreg_q[WIDTH-1:1]};
      default: shift_next = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.busy_o  = 1'b0;
    bus.done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (is_shift(bus.ALUoperation_i) && (shamt_in != '0)) state_d = ST_SHIFT;
          else                                                  state_d = ST_DONE;
        end
      end
      ST_SHIFT: begin
        bus.busy_o = 1'b1;
        if (cnt_q == SHAMT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.busy_o = 1'b1;
        bus.done_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      c_q      <= 1'b0;
      inv_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            op_q  <= bus.ALUoperation_i;
            c_q   <= bus.c_i;
            inv_q <= bus.invert_i;
            a_q   <= bus.a_i;
            b_q   <= bus.b_i;
            if (is_shift(bus.ALUoperation_i)) begin
              shreg_q <= bus.a_i;
              cnt_q   <= shamt_in;
              if (shamt_in == '0) begin
                result_q <= bus.a_i;
                zero_q   <= zero_val;
                lt_q     <= lt_val;
              end
            end else begin
              result_q <= alu_val;
              zero_q   <= zero_val;
              lt_q     <= lt_val;
            end
          end
        end
        ST_SHIFT: begin
          shreg_q <= shift_next;
          cnt_q   <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q <= shift_next;
            zero_q   <= zero_val;
            lt_q     <= lt_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.lt_o     = lt_q;

endmodule

// File: tb/tb_alu_iterativa.sv
// Scoreboard bench for alu_iterativa: reference model results queued at launch, compared at done.
module tb_alu_iterativa;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        lt;
    int          latency;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb[$];

  alu_iterativa_if #(.WIDTH(32)) bus ();

  alu_iterativa #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic c, input logic inv,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] bb;
    logic [32:0] usum;
    logic signed [33:0] ssum;
    logic signed [31:0] sa;
    int sh;
    bb   = inv ? ~b : b;
    usum = {1'b0, a} + {1'b0, bb} + {32'd0, c};
    ssum = $signed({a[31], a[31], a}) + $signed({bb[31], bb[31], bb}) + $signed({33'd0, c});
    sa   = a;
    sh   = int'(b[4:0]);
    e.zero    = (usum[31:0] == 32'd0);
    e.lt      = (op == OP_SLTU) ? ~usum[32] : (ssum < 0);
    e.latency = 1;
    case (op)
      OP_ADD, OP_SUB: e.result = usum[31:0];
      OP_AND:  e.result = a & b;
      OP_OR:   e.result = a | b;
      OP_XOR:  e.result = a ^ b;
      OP_SLT:  e.result = (ssum < 0) ? 32'd1 : 32'd0;
      OP_SLTU: e.result = usum[32] ? 32'd0 : 32'd1;
      OP_SLL:  e.result = a << sh;
      OP_SRL:  e.result = a >> sh;
      OP_SRA:  e.result = sa >>> sh;
      default: e.result = 32'd0;
    endcase
    if (is_shift(op) && sh != 0) e.latency = sh + 1;
    return e;
  endfunction

  // Launch one operation: start is sampled at the next rising edge, then dropped.
  task automatic apply_stimulus(input logic [3:0] op, input logic c, input logic inv,
                                input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ALUoperation_i = op;
    bus.c_i            = c;
    bus.invert_i       = inv;
    bus.a_i            = a;
    bus.b_i            = b;
    bus.start_i        = 1'b1;
    sb.push_back(model(op, c, inv, a, b));
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat0);
    exp_t e;
    int   lat;
    e   = sb.pop_front();
    lat = lat0;
    check_output({tag, " busy"}, {31'd0, bus.busy_o}, 32'd1);
    while (!bus.done_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output({tag, " done"}, {31'd0, bus.done_o}, 32'd1);
    check_output({tag, " latency"}, 32'(lat), 32'(e.latency));
    check_output({tag, " result"}, bus.result_o, e.result);
    check_output({tag, " zero"}, {31'd0, bus.zero_o}, {31'd0, e.zero});
    check_output({tag, " lt"}, {31'd0, bus.lt_o}, {31'd0, e.lt});
    @(posedge clk);
    #1;
    check_output({tag, " done pulse"}, {31'd0, bus.done_o}, 32'd0);
    check_output({tag, " idle"}, {31'd0, bus.busy_o}, 32'd0);
    check_output({tag, " held"}, bus.result_o, e.result);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " busy"}, {31'd0, bus.busy_o}, 32'd0);
    check_output({tag, " done"}, {31'd0, bus.done_o}, 32'd0);
    check_output({tag, " result"}, bus.result_o, 32'd0);
    check_output({tag, " zero"}, {31'd0, bus.zero_o}, 32'd0);
    check_output({tag, " lt"}, {31'd0, bus.lt_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int done_seen;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.start_i = 1'b0;
    bus.ALUoperation_i = 4'd0;
    bus.c_i = 1'b0;
    bus.invert_i = 1'b0;
    bus.a_i = 32'd0;
    bus.b_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus(OP_ADD, 1'b0, 1'b0, 32'd5, 32'd7);                 check_result("add", 1);
    apply_stimulus(OP_SUB, 1'b1, 1'b1, 32'h1234, 32'h1234);           check_result("sub_eq", 1);
    apply_stimulus(OP_SUB, 1'b1, 1'b1, 32'h8000_0000, 32'd1);         check_result("sub_ovf", 1);
    apply_stimulus(OP_SLT, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1);         check_result("slt", 1);
    apply_stimulus(OP_SLTU, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1);        check_result("sltu", 1);
    apply_stimulus(OP_AND, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00); check_result("and", 1);
    apply_stimulus(OP_OR, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00);  check_result("or", 1);
    apply_stimulus(OP_XOR, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00); check_result("xor", 1);
    apply_stimulus(4'b0111, 1'b1, 1'b1, 32'd3, 32'd9);                check_result("unsup", 1);
    apply_stimulus(OP_SRA, 1'b0, 1'b0, 32'h8000_0000, 32'd4);         check_result("sra", 1);
    apply_stimulus(OP_SRL, 1'b0, 1'b0, 32'h8000_0000, 32'd4);         check_result("srl", 1);
    apply_stimulus(OP_SRA, 1'b0, 1'b0, 32'h4000_00F0, 32'd7);         check_result("sra_pos", 1);
    apply_stimulus(OP_SLL, 1'b0, 1'b0, 32'hCAFE_BABE, 32'd0);         check_result("sll0", 1);
    apply_stimulus(OP_SLL, 1'b0, 1'b0, 32'd1, 32'd31);                check_result("sll31", 1);

    // A second start in the middle of a shift must not disturb it.
    apply_stimulus(OP_SLL, 1'b0, 1'b0, 32'h0000_00A5, 32'd8);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.ALUoperation_i = OP_ADD;
    bus.a_i = 32'h1111_1111;
    bus.b_i = 32'h2222_2222;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    check_result("sll_glitch", 5);

    // Reset during the third shift cycle of a 20-bit srl aborts it with no done.
    apply_stimulus(OP_SRL, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'd20);
    sb.delete();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    done_seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done_o) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done_o) done_seen++;
    end
    check_output("midreset no done", 32'(done_seen), 32'd0);
    check_output("midreset result", bus.result_o, 32'd0);

    apply_stimulus(OP_ADD, 1'b0, 1'b0, 32'd3, 32'd4);                 check_result("add_after", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_iterativa.md
Name: alu_iterativa

Overview:
- Execution-side consumer of the ALU control word: operation code, carry-in and invert-B.
- Sits between the register file/immediate mux and writeback in the multicycle datapath variant.
- Single-cycle ops (add/sub/logic/compare) complete in 1 cycle; shifts run iteratively, one bit per cycle.
- Exposes a start/busy/done handshake plus zero and less-than flags for branch resolution.

Parameters:
- WIDTH, 32, operand and result width.
- SHAMT_W, 5, shift-amount width, taken from b_i[SHAMT_W-1:0]; must equal clog2(WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  launches an operation; sampled only in IDLE.
- ALUoperation_i  in  4  op code: 0000 add, 0001 and, 0010 or, 0011 xor, 0100 sub, 0101 slt, 0110 sltu, 1000 sll, 1001 srl, 1010 sra.
- c_i  in  1  adder carry-in.
- invert_i  in  1  invert B operand into the adder.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B or immediate.
- busy_o  out  1  high while an operation is in progress.
- done_o  out  1  one-cycle pulse when the result is valid.
- result_o  out  WIDTH  registered result, held until the next done.
- zero_o  out  1  registered: adder sum == 0.
- lt_o  out  1  registered: signed A<B, or unsigned for op 0110.

Behaviour:
- Reset (async, rst_ni=0): state IDLE; busy_o=0, done_o=0, result_o=0, zero_o=0, lt_o=0; shift counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE with start_i=1: latch op, c_i, invert_i, a_i, b_i.
  - Non-shift op: compute, register the result, go to DONE.
  - Shift op with shamt>0: load the shift register with a_i, load counter=shamt, go to SHIFT.
  - Shift op with shamt=0: result=a_i, go to DONE.
- SHIFT: each cycle shift by 1 and decrement the counter.
  - sll fills with 0; srl fills with 0; sra fills with the MSB.
  - When counter reaches 1 the final shift is applied, then go to DONE.
- DONE: done_o=1 for exactly this cycle; next state is IDLE.
  - A start_i seen in DONE is ignored.
- busy_o=1 in SHIFT and DONE, and in the cycle after start is accepted.
- Latency from the start cycle to the done pulse: non-shift = 1 cycle; shift = shamt+1 cycles (max WIDTH).
- start_i while busy_o=1 is ignored, and the operands are not re-latched.
- Adder: sum = A + (invert ? ~B : B) + c, WIDTH+1 bits; carry = bit WIDTH.
- Overflow: A[msb]==B'[msb] && sum[msb]!=A[msb].
- slt result = {0…, sum[msb]^ovf}; sltu result = {0…, ~carry}. Both are valid only when invert=1 and c=1.
- zero_o and lt_o are updated at every done from the adder, for all ops.
  - lt_o = sum[msb]^ovf, except for op 0110 where lt_o = ~carry.
- Unsupported op codes (0111, 1011–1111): result 0, zero_o/lt_o per adder, done after 1 cycle.
- The invert and carry controls apply to every op code as given. The block does not validate whether the combination is meaningful.
- Reset asserted mid-SHIFT: abort immediately to the reset values; no done pulse is produced.
- result_o, zero_o and lt_o are held stable between done pulses.

Decomposition:
- Package alu_pkg holds:
  - 4-bit op code localparams: OP_ADD, OP_AND, OP_OR, OP_XOR, OP_SUB, OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA.
  - State encoding for IDLE/SHIFT/DONE.
- Sub-module alu_sumador (combinational):
  - Inputs: a, b, invert, c.
  - Outputs: sum, carry, overflow.
  - Shared by add/sub/slt/sltu and the flags.

Test Plan:
- add: op 0000, c=0, inv=0, a=5, b=7, start → done 1 cycle later, result=12, zero=0.
- sub/beq: op 0100, c=1, inv=1, a=b=0x1234 → result=0, zero_o=1. Repeat with a=0x80000000, b=1 → result=0x7FFFFFFF, lt_o=1.
- slt vs sltu: a=0xFFFFFFFF, b=1.
  - op 0101 → result=1, lt_o=1.
  - op 0110 → result=0, lt_o=0.
- sra: op 1010, a=0x80000000, b=4 → busy for 4 SHIFT cycles, done at cycle 5, result=0xF8000000. Same operands with srl → 0x08000000.
- Shift edge cases:
  - sll with b=0 → done at cycle 1, result=a.
  - sll with a=1, b=31 → done at cycle 32, result=0x80000000.
  - start_i pulsed mid-shift is ignored and the result is unchanged.
- Reset: assert rst_ni=0 at SHIFT cycle 3 of a 20-bit srl → outputs 0 immediately, no done pulse; a new add after release completes normally.
